// File: rtl/cond_unit.sv
// cond_unit -- E-stage condition/branch resolution for a dual-ISA (ARM / RISC-V) pipeline.
//
// Decides whether the instruction currently in E executes, gates its register
// and memory write enables, and resolves the fetch redirect (PCSrcE). It also
// owns the ARM {N,Z,C,V} flag register.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; loads FLAGS_RST into the flag register
//   armE        1 = ARM instruction in E, 0 = RISC-V
//   ALUFlags    {N,Z,C,V} produced by the E-stage ALU this cycle
//   CarryInvE   store C inverted (ARM subtract forms, where ALU C is a borrow)
//   CondE       ARM condition field
//   FlagWriteE  ARM flag write enables: [1] -> N,Z  [0] -> C,V
//   Funct3E     RISC-V branch type
//   BranchE     conditional branch in E
//   JumpE       unconditional jump in E
//   RegWriteE   decoder register write enable
//   MemWriteE   decoder memory write enable
//   StallE      hazard hold of E (outputs stay live, flags hold)
//   FlushE      kill of E (all outputs forced low, flags hold)
//   CondExE     E instruction executes
//   RegWriteGE  gated register write enable
//   MemWriteGE  gated memory write enable
//   PCSrcE      redirect fetch to the branch/jump target
//   BadBranchE  RISC-V branch with a reserved Funct3 encoding
//   FlagsQ      current registered {N,Z,C,V}

module cond_unit #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       armE,
  input  logic [3:0] ALUFlags,
  input  logic       CarryInvE,
  input  logic [3:0] CondE,
  input  logic [1:0] FlagWriteE,
  input  logic [2:0] Funct3E,
  input  logic       BranchE,
  input  logic       JumpE,
  input  logic       RegWriteE,
  input  logic       MemWriteE,
  input  logic       StallE,
  input  logic       FlushE,
  output logic       CondExE,
  output logic       RegWriteGE,
  output logic       MemWriteGE,
  output logic       PCSrcE,
  output logic       BadBranchE,
  output logic [3:0] FlagsQ
);

  // ARM condition codes come in complementary pairs: the upper three bits pick
  // the base test and bit 0 inverts it. 111x is "always" in both encodings.
  function automatic logic arm_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'b000:  base = z;
      3'b001:  base = c;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = c & ~z;
      3'b101:  base = (n == v);
      3'b110:  base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (cond[3:1] == 3'b111) ? 1'b1 : (base ^ cond[0]);
  endfunction

  // RISC-V branch decision from the subtract flags (C is a borrow, so it
  // directly means "unsigned less-than"). Reserved encodings never take.
  function automatic logic rv_take(input logic [2:0] f3, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (f3)
      3'b000:  return z;
      3'b001:  return ~z;
      3'b100:  return n ^ v;
      3'b101:  return ~(n ^ v);
      3'b110:  return c;
      3'b111:  return ~c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic rv_reserved(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  // Merge new ALU flags into the stored set under the per-pair write enables.
  // Only the carry is conditioned; N, Z and V are stored as produced.
  function automatic logic [3:0] merge_flags(input logic [3:0] cur, input logic [3:0] alu,
                                             input logic cinv, input logic [1:0] fw);
    logic [3:0] nxt;
    nxt = cur;
    if (fw[1]) nxt[3:2] = alu[3:2];
    if (fw[0]) nxt[1:0] = {alu[1] ^ cinv, alu[0]};
    return nxt;
  endfunction

  logic [3:0] flags_p1;
  logic       cond_ok_p0;
  logic       flag_en_p0;

  // ---- E stage: combinational resolution against registered flags ----
  always_comb begin
    cond_ok_p0 = armE ? arm_cond(CondE, flags_p1) : 1'b1;

    CondExE    = 1'b0;
    RegWriteGE = 1'b0;
    MemWriteGE = 1'b0;
    PCSrcE     = 1'b0;
    BadBranchE = 1'b0;

    if (!FlushE) begin
      CondExE    = cond_ok_p0;
      RegWriteGE = RegWriteE & cond_ok_p0;
      MemWriteGE = MemWriteE & cond_ok_p0;
      if (armE) begin
        PCSrcE = (BranchE | JumpE) & cond_ok_p0;
      end else begin
        PCSrcE     = JumpE | (BranchE & rv_take(Funct3E, ALUFlags));
        BadBranchE = BranchE & rv_reserved(Funct3E);
      end
    end

    flag_en_p0 = armE & cond_ok_p0 & ~StallE & ~FlushE;
  end

  // ---- E -> next cycle: flag register (1-cycle latency to consumers) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_p1 <= FLAGS_RST;
    end else if (flag_en_p0) begin
      flags_p1 <= merge_flags(flags_p1, ALUFlags, CarryInvE, FlagWriteE);
    end
  end

  assign FlagsQ = flags_p1;

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

  localparam logic [3:0] FR = 4'b1010;

  logic       clk = 1'b0;
  logic       reset;
  logic       armE;
  logic [3:0] ALUFlags;
  logic       CarryInvE;
  logic [3:0] CondE;
  logic [1:0] FlagWriteE;
  logic [2:0] Funct3E;
  logic       BranchE, JumpE, RegWriteE, MemWriteE, StallE, FlushE;
  logic       CondExE, RegWriteGE, MemWriteGE, PCSrcE, BadBranchE;
  logic [3:0] FlagsQ;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cond_unit #(.FLAGS_RST(FR)) dut (
    .clk(clk), .reset(reset), .armE(armE), .ALUFlags(ALUFlags), .CarryInvE(CarryInvE),
    .CondE(CondE), .FlagWriteE(FlagWriteE), .Funct3E(Funct3E), .BranchE(BranchE),
    .JumpE(JumpE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .StallE(StallE),
    .FlushE(FlushE), .CondExE(CondExE), .RegWriteGE(RegWriteGE), .MemWriteGE(MemWriteGE),
    .PCSrcE(PCSrcE), .BadBranchE(BadBranchE), .FlagsQ(FlagsQ)
  );

  typedef struct {
    logic       arm;
    logic [3:0] alu;
    logic       cinv;
    logic [3:0] cond;
    logic [1:0] fw;
    logic [2:0] f3;
    logic       br, jmp, rw, mw, stall, flush;
    logic       cex, rwg, mwg, pcs, bad;
    logic [3:0] fq;
  } vec_t;

  vec_t tbl[13];

  task automatic chk1(input string nm, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic cex, input logic rwg, input logic mwg,
                          input logic pcs, input logic bad);
    chk1({tag, ".CondExE"}, CondExE, cex);
    chk1({tag, ".RegWriteGE"}, RegWriteGE, rwg);
    chk1({tag, ".MemWriteGE"}, MemWriteGE, mwg);
    chk1({tag, ".PCSrcE"}, PCSrcE, pcs);
    chk1({tag, ".BadBranchE"}, BadBranchE, bad);
  endtask

  task automatic idle();
    reset = 1'b0; armE = 1'b0; ALUFlags = 4'b0000; CarryInvE = 1'b0; CondE = 4'b1110;
    FlagWriteE = 2'b00; Funct3E = 3'b000; BranchE = 1'b0; JumpE = 1'b0;
    RegWriteE = 1'b0; MemWriteE = 1'b0; StallE = 1'b0; FlushE = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    armE = v.arm; ALUFlags = v.alu; CarryInvE = v.cinv; CondE = v.cond; FlagWriteE = v.fw;
    Funct3E = v.f3; BranchE = v.br; JumpE = v.jmp; RegWriteE = v.rw; MemWriteE = v.mw;
    StallE = v.stall; FlushE = v.flush;
  endtask

  // Reference: ARM condition truth, spelled out per mnemonic.
  function automatic logic ref_arm(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  logic [3:0] mf;
  logic [7:0] a, b;
  logic [8:0] diff;
  logic       e_cex, e_pcs, e_bad, take;

  initial begin
    //           arm  alu      ci   cond     fw     f3      br jm rw mw st fl | cex rwg mwg pcs bad | fq
    tbl[0]  = '{1'b1, 4'b0110, 1'b1, 4'b1110, 2'b11, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0100};
    tbl[1]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'b00, 3'b000, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 4'b0100};
    tbl[2]  = '{1'b1, 4'b0000, 1'b0, 4'b1000, 2'b00, 3'b000, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0100};
    tbl[3]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'b11, 3'b000, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0100};
    tbl[4]  = '{1'b1, 4'b1011, 1'b0, 4'b1110, 2'b11, 3'b000, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 4'b0100};
    tbl[5]  = '{1'b0, 4'b1000, 1'b0, 4'b0000, 2'b11, 3'b100, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 4'b0100};
    tbl[6]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'b11, 3'b110, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b0100};
    tbl[7]  = '{1'b0, 4'b0100, 1'b0, 4'b0000, 2'b00, 3'b010, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 4'b0100};
    tbl[8]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'b00, 3'b010, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 4'b0100};
    tbl[9]  = '{1'b1, 4'b1011, 1'b1, 4'b1110, 2'b10, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4'b1000};
    tbl[10] = '{1'b1, 4'b0010, 1'b1, 4'b1010, 2'b01, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000};
    tbl[11] = '{1'b1, 4'b0000, 1'b1, 4'b1011, 2'b01, 3'b000, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 4'b1010};
    tbl[12] = '{1'b1, 4'b0000, 1'b0, 4'b1111, 2'b00, 3'b000, 1, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0, 4'b1010};

    idle();

    // Reset with a competing flag write; outputs stay live during reset.
    @(negedge clk);
    reset = 1'b1; armE = 1'b1; CondE = 4'b1110; FlagWriteE = 2'b11; ALUFlags = 4'b1111;
    @(posedge clk); #1;
    chk4("reset.FlagsQ", FlagsQ, FR);
    @(negedge clk);
    CondE = 4'b0100; FlagWriteE = 2'b00; RegWriteE = 1'b1; #1;
    chk_outs("reset.MI", 1, 1, 0, 0, 0);
    CondE = 4'b0101; #1;
    chk_outs("reset.PL", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk4("reset.hold", FlagsQ, FR);

    // Table sequence from the reset flags.
    @(negedge clk);
    idle();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      chk_outs($sformatf("tbl%0d", i), tbl[i].cex, tbl[i].rwg, tbl[i].mwg, tbl[i].pcs, tbl[i].bad);
      @(posedge clk); #1;
      chk4($sformatf("tbl%0d.FlagsQ", i), FlagsQ, tbl[i].fq);
    end

    // Stall for three cycles, then release: exactly one update afterwards.
    @(negedge clk);
    idle();
    armE = 1'b1; CondE = 4'b1110; FlagWriteE = 2'b11; ALUFlags = 4'b0101; RegWriteE = 1'b1;
    StallE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1($sformatf("stall%0d.RegWriteGE", k), RegWriteGE, 1'b1);
      @(posedge clk); #1;
      chk4($sformatf("stall%0d.FlagsQ", k), FlagsQ, 4'b1010);
      @(negedge clk);
    end
    StallE = 1'b0;
    @(posedge clk); #1;
    chk4("stall.release", FlagsQ, 4'b0101);
    @(negedge clk);
    FlagWriteE = 2'b00; ALUFlags = 4'b1111;
    @(posedge clk); #1;
    chk4("stall.after", FlagsQ, 4'b0101);

    // Stall and flush together: gated outputs, flags hold.
    @(negedge clk);
    StallE = 1'b1; FlushE = 1'b1; FlagWriteE = 2'b11; MemWriteE = 1'b1; BranchE = 1'b1; #1;
    chk_outs("stallflush", 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk4("stallflush.FlagsQ", FlagsQ, 4'b0101);

    // Reset between a flag write and its consumer discards the write.
    @(negedge clk);
    idle();
    armE = 1'b1; CondE = 4'b1110; FlagWriteE = 2'b11; ALUFlags = 4'b1100;
    @(posedge clk); #1;
    chk4("midrst.write", FlagsQ, 4'b1100);
    @(negedge clk);
    reset = 1'b1; FlagWriteE = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0; CondE = 4'b0000; RegWriteE = 1'b1; #1;
    chk_outs("midrst.EQ", 0, 0, 0, 0, 0);
    chk4("midrst.FlagsQ", FlagsQ, FR);

    // Reset racing a valid write of all-ones.
    @(negedge clk);
    idle();
    armE = 1'b1; CondE = 4'b1110; FlagWriteE = 2'b11; ALUFlags = 4'b0001;
    @(posedge clk); #1;
    chk4("rstwr.pre", FlagsQ, 4'b0001);
    @(negedge clk);
    reset = 1'b1; ALUFlags = 4'b1111;
    @(posedge clk); #1;
    chk4("rstwr.FlagsQ", FlagsQ, FR);

    // Randomized traffic against the reference model.
    mf = FR;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 19) == 0);
      armE       = 1'($urandom);
      CarryInvE  = 1'($urandom);
      CondE      = 4'($urandom);
      FlagWriteE = 2'($urandom);
      Funct3E    = 3'($urandom);
      BranchE    = 1'($urandom);
      JumpE      = ($urandom_range(0, 3) == 0);
      RegWriteE  = 1'($urandom);
      MemWriteE  = 1'($urandom);
      StallE     = ($urandom_range(0, 4) == 0);
      FlushE     = ($urandom_range(0, 7) == 0);
      take = 1'b0;
      if (armE) begin
        ALUFlags = 4'($urandom);
      end else begin
        // RISC-V: flags come from a real subtract of two operands; the branch
        // outcome is judged from the operands themselves.
        a = 8'($urandom);
        b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
        diff = {1'b0, a} - {1'b0, b};
        ALUFlags = {diff[7], diff[7:0] == 8'd0, a < b, (a[7] != b[7]) && (diff[7] != a[7])};
        case (Funct3E)
          3'd0: take = (a == b);
          3'd1: take = (a != b);
          3'd4: take = ($signed(a) < $signed(b));
          3'd5: take = ($signed(a) >= $signed(b));
          3'd6: take = (a < b);
          3'd7: take = (a >= b);
          default: take = 1'b0;
        endcase
      end
      e_cex = !FlushE && (!armE || ref_arm(CondE, mf));
      if (FlushE)    e_pcs = 1'b0;
      else if (armE) e_pcs = (BranchE || JumpE) && e_cex;
      else           e_pcs = JumpE || (BranchE && take);
      e_bad = !FlushE && !armE && BranchE && (Funct3E == 3'd2 || Funct3E == 3'd3);
      #1;
      chk4($sformatf("rnd%0d.FlagsQ", i), FlagsQ, mf);
      chk_outs($sformatf("rnd%0d", i), e_cex, RegWriteE && e_cex, MemWriteE && e_cex, e_pcs, e_bad);
      if (reset) begin
        mf = FR;
      end else if (armE && e_cex && !StallE && !FlushE) begin
        if (FlagWriteE[1]) mf[3:2] = ALUFlags[3:2];
        if (FlagWriteE[0]) mf[1:0] = {ALUFlags[1] ^ CarryInvE, ALUFlags[0]};
      end
      @(posedge clk);
    end
    #1;
    chk4("rnd.final", FlagsQ, mf);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 Parameter: FLAGS_RST, default 4'b0000, reset value of the flag register {N,Z,C,V}.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 armE  input  1  1 = ARM instruction in E stage, 0 = RISC-V.
REQ-005 ALUFlags  input  4  {N,Z,C,V} from the E-stage ALU, same cycle.
REQ-006 CarryInvE  input  1  1 = store C inverted; decoder sets it for ARM SUB/RSB/CMP, where the ALU's C is borrow.
REQ-007 CondE  input  4  ARM condition field.
REQ-008 FlagWriteE  input  2  ARM: [1] updates N,Z; [0] updates C,V.
REQ-009 Funct3E  input  3  RISC-V branch type.
REQ-010 BranchE, JumpE  input  1 each  branch / unconditional jump in E.
REQ-011 RegWriteE, MemWriteE  input  1 each  decoder write enables.
REQ-012 StallE, FlushE  input  1 each  hazard-unit hold / kill of the E instruction.
REQ-013 CondExE  output  1  E instruction executes.
REQ-014 RegWriteGE, MemWriteGE  output  1 each  gated write enables.
REQ-015 PCSrcE  output  1  redirect fetch to the branch/jump target.
REQ-016 BadBranchE  output  1  RISC-V branch with reserved Funct3.
REQ-017 FlagsQ  output  4  current registered {N,Z,C,V}.

Function
REQ-018 ARM conditions are evaluated against FlagsQ, never against ALUFlags: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 1.
REQ-019 When armE=0, CondExE = 1.
REQ-020 When FlushE=1, all of CondExE, RegWriteGE, MemWriteGE, PCSrcE and BadBranchE are 0.
REQ-021 RegWriteGE = RegWriteE&CondExE; MemWriteGE = MemWriteE&CondExE. Both are purely combinational with zero latency.
REQ-022 ARM: PCSrcE = (BranchE|JumpE)&CondExE.
REQ-023 RISC-V: PCSrcE = JumpE | (BranchE & take), with take taken from ALUFlags of the same cycle (ALU performs Op1-Op2, C = borrow): 000 Z; 001 !Z; 100 N^V; 101 !(N^V); 110 C; 111 !C.
REQ-024 RISC-V BranchE with Funct3 010 or 011 gives take=0 and BadBranchE=1. BadBranchE is 0 in every other case.
REQ-025 Stored value: Cnew = ALUFlags[1]^CarryInvE; N, Z and V are stored unmodified.
REQ-026 The flag register updates at a clock edge only when armE & CondExE & !StallE & !FlushE & !reset. Bits [3:2] update when FlagWriteE[1]; bits [1:0] update when FlagWriteE[0]; other bits hold.
REQ-027 The new flags are visible on FlagsQ and used by CondExE in the next cycle (1-cycle latency), so back-to-back CMP then conditional instruction needs no bypass.
REQ-028 RISC-V instructions never modify the flag register.
REQ-029 While StallE=1, the outputs are still driven combinationally from the current inputs and the flag register holds. The instruction re-evaluates with identical flags when the stall releases.
REQ-030 When StallE and FlushE are both 1, the flush gating of REQ-020 applies and the flag register holds.

Reset
REQ-031 When reset=1 at a clock edge, FlagsQ becomes FLAGS_RST, overriding any flag write in the same cycle.
REQ-032 Combinational outputs remain functional during reset and follow REQ-018..REQ-024 using FlagsQ = FLAGS_RST after the first reset edge.
REQ-033 Reset asserted mid-sequence (between a flag write and its consumer) discards the written flags.

Verification
REQ-034 ARM CMP: ALUFlags=4'b0110, CarryInvE=1, FlagWriteE=2'b11, CondE=AL -> next cycle FlagsQ=4'b0100. A following CondE=EQ -> CondExE=1; a following CondE=HI -> CondExE=0.
REQ-035 ARM conditional: CondE=NE, FlagsQ Z=1, RegWriteE=1, MemWriteE=1, BranchE=1 -> RegWriteGE=0, MemWriteGE=0, PCSrcE=0, and FlagsQ unchanged even with FlagWriteE=2'b11.
REQ-036 RISC-V: Funct3=100 with ALUFlags N=1,V=0 -> PCSrcE=1; Funct3=110 with C=0 -> PCSrcE=0; Funct3=010 -> PCSrcE=0 and BadBranchE=1; JumpE=1 -> PCSrcE=1; FlagsQ constant throughout.
REQ-037 StallE=1 with FlagWriteE=2'b11 for 3 cycles -> FlagsQ holds. StallE drops -> a single update occurs.
REQ-038 FlushE=1 with ARM AL, FlagWriteE=2'b11 -> all outputs 0 and FlagsQ holds.
REQ-039 reset=1 in the same cycle as a valid flag write of 4'b1111 -> FlagsQ=FLAGS_RST next cycle.
